decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_regfile.sv | 59 +++++
 rtl/decoder.sv | 67 ++++++
 tb/tb_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants for the instruction decoder and its register file.
//   - I-type opcodes whose immediates are zero-extended (andi/ori/xori)
//   - register index of the JAL link register ($ra)
//   - helper that classifies an opcode as zero-extending
package decoder_pkg;

   localparam int unsigned REG_W   = 32;
   localparam int unsigned NUM_REG = 32;
   localparam int unsigned ADDR_W  = 5;

   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110;

   localparam logic [ADDR_W-1:0] REG_RA = 5'd31;

   // Logical immediates are treated as unsigned; everything else is signed.
   function automatic logic is_zext_op(input logic [5:0] opcode);
      return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
   endfunction

endpackage

// File: rtl/decoder_regfile.sv
// 32 x 32-bit register file.
//   clk, rst      : clock and synchronous active-high reset (clears all regs)
//   raddr1_i/2_i  : asynchronous read addresses
//   rdata1_o/2_o  : asynchronous read data (old value during a same-cycle write)
//   we_i          : write enable
//   waddr_i       : write address (writes to $0 are dropped)
//   wdata_i       : write data
//   regs_o        : full register contents, $0 always reads 0
module regfile
   import decoder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr1_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [REG_W-1:0]  rdata1_o,
   output logic [REG_W-1:0]  rdata2_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [REG_W-1:0]  wdata_i,
   output logic [REG_W-1:0]  regs_o [0:NUM_REG-1]
);

   // $0 has no storage at all, so it cannot be written or reset to anything else.
   logic [REG_W-1:0] regs_q [1:NUM_REG-1];
   logic [REG_W-1:0] regs_d [1:NUM_REG-1];
   logic [REG_W-1:0] view   [0:NUM_REG-1];

   always_comb begin
      for (int i = 1; i < NUM_REG; i++) begin
         regs_d[i] = regs_q[i];
         if (we_i && (waddr_i == ADDR_W'(i))) begin
            regs_d[i] = wdata_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 1; i < NUM_REG; i++) begin
         if (rst) begin
            regs_q[i] <= '0;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      view[0] = '0;
      for (int i = 1; i < NUM_REG; i++) begin
         view[i] = regs_q[i];
      end
   end

   assign rdata1_o = view[raddr1_i];
   assign rdata2_o = view[raddr2_i];
   assign regs_o   = view;

endmodule

// File: rtl/decoder.sv
// Instruction decode stage: register-file reads, immediate extension and
// write-back source/destination selection.
//   clk, rst                 : clock, synchronous active-high reset
//   Instruction              : current instruction word
//   read_data, ALU_result    : write-back candidates (load data / ALU)
//   opcplus4                 : PC+4, written to $ra on JAL
//   Jal, RegWrite, MemtoReg, RegDst : control from the main decoder
//   read_data_1/2            : contents of rs / rt (combinational)
//   Sign_extend              : extended 16-bit immediate (combinational)
//   register                 : debug view of all 32 registers
module decoder
   import decoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instruction,
   input  logic [31:0] read_data,
   input  logic [31:0] ALU_result,
   input  logic        Jal,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic        RegDst,
   input  logic [31:0] opcplus4,
   output logic [31:0] read_data_1,
   output logic [31:0] read_data_2,
   output logic [31:0] Sign_extend,
   output logic [31:0] register [0:31]
);

   logic [5:0]        opcode;
   logic [ADDR_W-1:0] rs, rt, rd;
   logic [15:0]       imm;
   logic [ADDR_W-1:0] waddr;
   logic [REG_W-1:0]  wdata;

   assign opcode = Instruction[31:26];
   assign rs     = Instruction[25:21];
   assign rt     = Instruction[20:16];
   assign rd     = Instruction[15:11];
   assign imm    = Instruction[15:0];

   assign Sign_extend = is_zext_op(opcode) ? {16'h0000, imm} : {{16{imm[15]}}, imm};

   // JAL overrides both the destination and the data source.
   always_comb begin
      waddr = RegDst ? rd : rt;
      wdata = MemtoReg ? read_data : ALU_result;
      if (Jal) begin
         waddr = REG_RA;
         wdata = opcplus4;
      end
   end

   regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .raddr1_i (rs),
      .raddr2_i (rt),
      .rdata1_o (read_data_1),
      .rdata2_o (read_data_2),
      .we_i     (RegWrite),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .regs_o   (register)
   );

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

   logic        clk;
   logic        rst;
   logic [31:0] Instruction;
   logic [31:0] read_data;
   logic [31:0] ALU_result;
   logic        Jal;
   logic        RegWrite;
   logic        MemtoReg;
   logic        RegDst;
   logic [31:0] opcplus4;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;
   logic [31:0] Sign_extend;
   logic [31:0] register [0:31];

   // Reference register file state.
   logic [31:0] model [0:31];

   int n_checks;
   int n_fail;

   decoder dut (
      .clk         (clk),
      .rst         (rst),
      .Instruction (Instruction),
      .read_data   (read_data),
      .ALU_result  (ALU_result),
      .Jal         (Jal),
      .RegWrite    (RegWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .opcplus4    (opcplus4),
      .read_data_1 (read_data_1),
      .read_data_2 (read_data_2),
      .Sign_extend (Sign_extend),
      .register    (register)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate extension from the instruction-set rules: andi/ori/xori
   // (opcodes 12, 13, 14) take the immediate as unsigned, others as signed.
   function automatic logic [31:0] ref_ext(input logic [31:0] ins);
      int unsigned opc;
      int unsigned imm;
      opc = ins >> 26;
      imm = ins & 32'h0000_FFFF;
      if (opc == 12 || opc == 13 || opc == 14) return imm;
      if (imm >= 32768) return imm + 32'hFFFF_0000;
      return imm;
   endfunction

   // Advance the reference by one clock edge using the current inputs.
   function automatic void ref_clock();
      int unsigned dest;
      logic [31:0] data;
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         return;
      end
      if (!RegWrite) return;
      if (Jal) begin
         dest = 31;
         data = opcplus4;
      end else begin
         dest = RegDst ? ((Instruction >> 11) & 31) : ((Instruction >> 16) & 31);
         data = MemtoReg ? read_data : ALU_result;
      end
      if (dest != 0) model[dest] = data;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] rdat, input logic jal, input logic we,
                        input logic m2r, input logic dst, input logic [31:0] pc4);
      Instruction = ins;
      ALU_result  = alu;
      read_data   = rdat;
      Jal         = jal;
      RegWrite    = we;
      MemtoReg    = m2r;
      RegDst      = dst;
      opcplus4    = pc4;
      #1;
   endtask

   // Clock one edge, updating the reference alongside; returns 1ns after the edge.
   task automatic step();
      @(posedge clk);
      ref_clock();
      #1;
   endtask

   task automatic test_reset();
      drive(32'h0043_3820, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         n_checks++;
         if (register[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg[%0d] got %h expected %h", i, register[i], 32'h0);
         end
      end
      n_checks++;
      if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_reads got %h/%h expected 0/0", read_data_1, read_data_2);
      end
   endtask

   task automatic test_directed();
      // add $7,$2,$3
      drive(32'h0043_3820, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      n_checks++;
      if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
         n_fail++;
         $display("FAIL add_reads got %h/%h expected 0/0", read_data_1, read_data_2);
      end
      step();
      n_checks++;
      if (register[7] !== 32'h5) begin
         n_fail++;
         $display("FAIL add_r7 got %h expected %h", register[7], 32'h5);
      end
      // addi $3,$7,0x8037
      drive(32'h20E3_8037, 32'hFFFF_803C, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (read_data_1 !== 32'h5) begin
         n_fail++;
         $display("FAIL addi_rs got %h expected %h", read_data_1, 32'h5);
      end
      n_checks++;
      if (Sign_extend !== 32'hFFFF_8037) begin
         n_fail++;
         $display("FAIL addi_ext got %h expected %h", Sign_extend, 32'hFFFF_8037);
      end
      step();
      n_checks++;
      if (register[3] !== 32'hFFFF_803C) begin
         n_fail++;
         $display("FAIL addi_r3 got %h expected %h", register[3], 32'hFFFF_803C);
      end
      // andi $4,$2,0x8097
      drive(32'h3044_8097, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (Sign_extend !== 32'h0000_8097) begin
         n_fail++;
         $display("FAIL andi_ext got %h expected %h", Sign_extend, 32'h0000_8097);
      end
      step();
      n_checks++;
      if (register[4] !== 32'h2) begin
         n_fail++;
         $display("FAIL andi_r4 got %h expected %h", register[4], 32'h2);
      end
      // sll $5,$1,2
      drive(32'h0001_2880, 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      step();
      n_checks++;
      if (register[5] !== 32'h4) begin
         n_fail++;
         $display("FAIL sll_r5 got %h expected %h", register[5], 32'h4);
      end
      // lw $6,0x100($0)
      drive(32'h8C06_0100, 32'h54, 32'h7B, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      n_checks++;
      if (register[6] !== 32'h7B) begin
         n_fail++;
         $display("FAIL lw_r6 got %h expected %h", register[6], 32'h7B);
      end
      // jal
      drive(32'h0C00_0010, 32'h99, 32'h77, 1'b1, 1'b1, 1'b0, 1'b1, 32'h18);
      step();
      n_checks++;
      if (register[31] !== 32'h18) begin
         n_fail++;
         $display("FAIL jal_r31 got %h expected %h", register[31], 32'h18);
      end
      // write to $0
      drive(32'h0000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      step();
      n_checks++;
      if (register[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_reg got %h expected %h", register[0], 32'h0);
      end
      // RegWrite=0 leaves everything alone
      drive(32'h00E0_3820, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step();
      for (int i = 0; i < 32; i++) begin
         n_checks++;
         if (register[i] !== model[i]) begin
            n_fail++;
            $display("FAIL nowrite_reg[%0d] got %h expected %h", i, register[i], model[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      drive(32'h00E3_3820, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         n_checks++;
         if (register[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_reg[%0d] got %h expected %h", i, register[i], 32'h0);
         end
      end
   endtask

   task automatic test_random(input int cycles);
      logic [31:0] ins;
      logic [31:0] exp1, exp2;
      for (int c = 0; c < cycles; c++) begin
         ins = $urandom;
         // Bias opcodes toward the logical-immediate group now and then.
         if ($urandom_range(0, 3) == 0) ins[31:26] = 6'(12 + $urandom_range(0, 2));
         drive(ins, $urandom, $urandom, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom);
         rst = ($urandom_range(0, 39) == 0);
         #1;
         exp1 = model[(ins >> 21) & 31];
         exp2 = model[(ins >> 16) & 31];
         n_checks++;
         if (read_data_1 !== exp1) begin
            n_fail++;
            $display("FAIL rand_rd1 cycle %0d got %h expected %h", c, read_data_1, exp1);
         end
         n_checks++;
         if (read_data_2 !== exp2) begin
            n_fail++;
            $display("FAIL rand_rd2 cycle %0d got %h expected %h", c, read_data_2, exp2);
         end
         n_checks++;
         if (Sign_extend !== ref_ext(ins)) begin
            n_fail++;
            $display("FAIL rand_ext cycle %0d got %h expected %h", c, Sign_extend, ref_ext(ins));
         end
         step();
         for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (register[i] !== model[i]) begin
               n_fail++;
               $display("FAIL rand_reg[%0d] cycle %0d got %h expected %h", i, c, register[i], model[i]);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      rst = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      test_reset();
      test_directed();
      test_mid_reset();
      test_random(300);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
